led_pattern_sequencer: RTL and testbench
========================================

// Module: led_pattern_sequencer
// PURPOSE
//  Controller for the 8-LED display register. It sequences four animation modes
//  at a divided tick rate and advances the mode on a debounced pushbutton press.
//  A pause switch freezes the animation. It sits between the board I/O
//  (CLK_12MHz, button, switch) and the LED pins.
// PARAMETERS
//  TICK_DIV    600000  CLK_12MHz cycles per animation step (20 Hz at 12 MHz); must be >=2
//  DEB_CYCLES  120000  consecutive stable samples before the button level is accepted (10 ms); >=2
// PORTS
//  CLK_12MHz   in   1  sole clock; all state on its rising edge
//  RST_N       in   1  reset, asynchronous assert, active-low
//  MODE_BTN_N  in   1  raw pushbutton, active-low, asynchronous to CLK_12MHz
//  PAUSE_N     in   1  slide switch; low = pause; treated as quasi-static (2-flop synced, not debounced)
//  LED         out  8  LED drive, 1 = lit, registered
//  MODE        out  2  current mode, registered
// BEHAVIOUR
//  Reset (RST_N low, async): LED=8'h01, MODE=0 (WALK), bounce dir=left, tick counter=0,
//   debounce counter=0, sync flops=1, debounced level=1 (released), press pulse=0.
//  Input sync: MODE_BTN_N and PAUSE_N each pass through 2 flops before any use.
//  Debounce: while synced button != debounced level, count up; otherwise clear the count.
//   When the count reaches DEB_CYCLES-1 with a mismatch still present, the debounced
//   level takes the synced value and the count clears. press = 1-cycle pulse on the
//   debounced 1->0 edge. Release generates no event.
//  Tick: counter runs 0..TICK_DIV-1 and wraps; tick=1 in the cycle the counter equals
//   TICK_DIV-1. Counter holds its value while paused. Counter clears to 0 on press.
//  Step: on tick with pause inactive and no press, LED advances per mode:
//   WALK(0)   rotate left: 01,02,04..80,01
//   BOUNCE(1) one lit bit; shift in dir; at 80 dir->right, at 01 dir->left:
//             01,02..80,40..01,02
//   BLINK(2)  LED = ~LED: FF,00,FF
//   FILL(3)   LED = {LED[6:0], ~LED[7]}: 00,01,03..7F,FF,FE,FC..80,00
//             (8-bit Johnson count)
//  Mode FSM: WALK->BOUNCE->BLINK->FILL->WALK, advanced only by press.
//   On press, the next cycle shows the new MODE and the seed LED value:
//   WALK 01, BOUNCE 01 with dir=left, BLINK FF, FILL 00.
//  Press is accepted while paused (mode and seed load); the animation stays frozen.
//  Press and tick in the same cycle: press wins, the step is dropped, and the
//   counter clears.
//  Latency: MODE_BTN_N fall -> MODE change = 2 (sync) + DEB_CYCLES + 1 (pulse->reg) cycles.
//   tick -> LED update = 1 cycle.
//  Pause: LED, dir and tick counter hold exactly; resuming continues from the held
//   counter value.
//  RST_N mid-animation: outputs return to reset values immediately (async).
//   Operation restarts in WALK after deassertion.
// STRUCTURE
//  Shared header led_pkg: mode codes (MODE_WALK=0 .. MODE_FILL=3) and per-mode seed
//   constants, so a top-level or status block can decode MODE.
//  Sub-module led_debounce (params DEB_CYCLES): 2-flop sync, stable counter,
//   debounced level, falling-edge press pulse.
//  Top: tick divider, mode FSM, LED/dir registers, PAUSE_N sync.
// TESTING (bench overrides TICK_DIV=4, DEB_CYCLES=3)
//  1 Reset, no press, run 9 ticks -> LED 01 then 02,04,08,10,20,40,80,01,02; MODE=0.
//  2 One clean press -> MODE=1, LED=01. Run 15 ticks -> 02..80,40,20,10,08,04,02,01,02.
//  3 Button low for 2 cycles (glitch) -> no press, MODE unchanged.
//    Held 10 cycles -> exactly one advance.
//    Press from FILL -> MODE=0, LED=01.
//  4 BLINK, PAUSE_N low for 20 cycles -> LED constant.
//    Release -> next toggle comes after the remaining held counter cycles.
//  5 Press pulse aligned with the tick cycle -> no step. Seed loaded.
//    Next step exactly TICK_DIV cycles later.
//  6 FILL at LED=0F, RST_N low mid-cycle -> LED=01, MODE=0 before the next edge.
//    Release -> WALK resumes after TICK_DIV cycles.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer.
// Mode codes match the value driven on the MODE output, so any status or
// display block can decode MODE by importing this package. Each mode has a
// seed LED value that is loaded when the mode is entered.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_WALK   = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    localparam logic [7:0] SEED_WALK   = 8'h01;
    localparam logic [7:0] SEED_BOUNCE = 8'h01;
    localparam logic [7:0] SEED_BLINK  = 8'hFF;
    localparam logic [7:0] SEED_FILL   = 8'h00;

    // Button-driven mode order: WALK -> BOUNCE -> BLINK -> FILL -> WALK
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_WALK:   next_mode = MODE_BOUNCE;
            MODE_BOUNCE: next_mode = MODE_BLINK;
            MODE_BLINK:  next_mode = MODE_FILL;
            default:     next_mode = MODE_WALK;
        endcase
    endfunction

    function automatic logic [7:0] mode_seed(input mode_e m);
        case (m)
            MODE_WALK:   mode_seed = SEED_WALK;
            MODE_BOUNCE: mode_seed = SEED_BOUNCE;
            MODE_BLINK:  mode_seed = SEED_BLINK;
            default:     mode_seed = SEED_FILL;
        endcase
    endfunction

endpackage

// File: rtl/led_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, stable-sample counter,
// debounced level and a one-cycle pulse on the debounced press (1->0) edge.
// Ports:
//   i_clk    in  1  clock
//   i_rst_n  in  1  asynchronous active-low reset
//   i_btn_n  in  1  raw active-low button, asynchronous to i_clk
//   o_press  out 1  registered one-cycle pulse per accepted press
module led_debounce #(
    parameter int DEB_CYCLES = 120000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int DCW = $clog2(DEB_CYCLES);
    localparam logic [DCW-1:0] CNT_LAST = DCW'(DEB_CYCLES - 1);

    logic           r_sync1;
    logic           r_sync2;
    logic           r_level;
    logic           r_press;
    logic [DCW-1:0] r_cnt;

    logic w_mismatch;
    logic w_accept;

    // The counter only advances while the synced input disagrees with the
    // accepted level; any agreeing sample restarts the stability window.
    assign w_mismatch = (r_sync2 != r_level);
    assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            if (w_accept) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_mismatch) begin
                r_cnt <= r_cnt + DCW'(1);
            end else begin
                r_cnt <= '0;
            end
            // Only the accepted transition to "pressed" produces an event
            r_press <= w_accept && !r_sync2;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/led_pattern_sequencer.sv
// 8-LED animation controller. A divided tick steps the current animation;
// a debounced button press advances the mode and loads that mode's seed;
// a synchronised pause switch freezes LEDs, bounce direction and tick counter.
// Ports:
//   CLK_12MHz   in  1  clock
//   RST_N       in  1  asynchronous active-low reset
//   MODE_BTN_N  in  1  raw active-low mode button
//   PAUSE_N     in  1  pause switch, low = paused
//   LED         out 8  registered LED drive, 1 = lit
//   MODE        out 2  registered current mode (led_pkg::mode_e encoding)
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int TICK_DIV   = 600000,
    parameter int DEB_CYCLES = 120000
) (
    input  logic       CLK_12MHz,
    input  logic       RST_N,
    input  logic       MODE_BTN_N,
    input  logic       PAUSE_N,
    output logic [7:0] LED,
    output logic [1:0] MODE
);

    localparam int TCW = $clog2(TICK_DIV);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);

    logic           r_pause_s1;
    logic           r_pause_s2;
    logic [TCW-1:0] r_tick_cnt;
    mode_e          r_mode;
    logic [7:0]     r_led;
    logic           r_dir_left;

    logic           w_press;
    logic           w_tick;
    logic           w_paused;
    logic           w_bounce_left;
    logic [TCW-1:0] w_tick_cnt_next;
    mode_e          w_mode_next;
    logic [7:0]     w_led_next;
    logic           w_dir_next;

    led_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .i_clk   (CLK_12MHz),
        .i_rst_n (RST_N),
        .i_btn_n (MODE_BTN_N),
        .o_press (w_press)
    );

    assign w_paused = !r_pause_s2;
    assign w_tick   = (r_tick_cnt == TICK_LAST);

    // Bounce reverses at the end LEDs: the end value itself decides the new
    // direction, so 80 steps to 40 and 01 steps to 02 in the same tick.
    always_comb begin
        w_bounce_left = r_dir_left;
        if (r_led == 8'h80) begin
            w_bounce_left = 1'b0;
        end else if (r_led == 8'h01) begin
            w_bounce_left = 1'b1;
        end
    end

    always_comb begin
        w_mode_next     = r_mode;
        w_led_next      = r_led;
        w_dir_next      = r_dir_left;
        w_tick_cnt_next = r_tick_cnt;

        if (w_press) begin
            // Press overrides a coincident tick and restarts the step period
            w_mode_next     = next_mode(r_mode);
            w_led_next      = mode_seed(next_mode(r_mode));
            w_dir_next      = 1'b1;
            w_tick_cnt_next = '0;
        end else if (!w_paused) begin
            if (w_tick) begin
                w_tick_cnt_next = '0;
                case (r_mode)
                    MODE_WALK: begin
                        w_led_next = {r_led[6:0], r_led[7]};
                    end
                    MODE_BOUNCE: begin
                        w_dir_next = w_bounce_left;
                        w_led_next = w_bounce_left ? {r_led[6:0], 1'b0}
                                                   : {1'b0, r_led[7:1]};
                    end
                    MODE_BLINK: begin
                        w_led_next = ~r_led;
                    end
                    default: begin
                        // Johnson counter: fills with ones, then drains
                        w_led_next = {r_led[6:0], ~r_led[7]};
                    end
                endcase
            end else begin
                w_tick_cnt_next = r_tick_cnt + TCW'(1);
            end
        end
    end

    always_ff @(posedge CLK_12MHz or negedge RST_N) begin
        if (!RST_N) begin
            r_pause_s1 <= 1'b1;
            r_pause_s2 <= 1'b1;
            r_tick_cnt <= '0;
            r_mode     <= MODE_WALK;
            r_led      <= SEED_WALK;
            r_dir_left <= 1'b1;
        end else begin
            r_pause_s1 <= PAUSE_N;
            r_pause_s2 <= r_pause_s1;
            r_tick_cnt <= w_tick_cnt_next;
            r_mode     <= w_mode_next;
            r_led      <= w_led_next;
            r_dir_left <= w_dir_next;
        end
    end

    assign LED  = r_led;
    assign MODE = r_mode;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;

    localparam int TD  = 4;
    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_n;
    logic       pause_n;
    logic [7:0] led;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    // Reference model: mode, position in the mode's pattern list, and how
    // many unpaused cycles have elapsed in the current step period.
    int m_mode  = 0;
    int m_pos   = 0;
    int m_phase = 0;
    int m_cyc   = 0;
    bit h1 = 1'b1;
    bit h2 = 1'b1;
    int m_press_edge = -1;

    // Button request handshake to the driver process
    int btn_len  = 0;
    int btn_seq  = 0;
    int btn_ack  = 0;
    int btn_left = 0;

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .TICK_DIV   (TD),
        .DEB_CYCLES (DEB)
    ) dut (
        .CLK_12MHz  (clk),
        .RST_N      (rst_n),
        .MODE_BTN_N (btn_n),
        .PAUSE_N    (pause_n),
        .LED        (led),
        .MODE       (mode)
    );

    // LED value at position pos of each mode's animation list
    function automatic logic [7:0] pat(input int md, input int pos);
        int p;
        case (md)
            0: pat = 8'h01 << (pos % 8);
            1: begin
                p = pos % 14;
                pat = (p <= 7) ? (8'h01 << p) : (8'h01 << (14 - p));
            end
            2: pat = ((pos % 2) == 0) ? 8'hFF : 8'h00;
            default: begin
                p = pos % 16;
                if (p <= 8) pat = 8'((9'h001 << p) - 9'h001);
                else        pat = 8'(8'hFF << (p - 8));
            end
        endcase
    endfunction

    function automatic logic [7:0] exp_led();
        return pat(m_mode, m_pos);
    endfunction

    // Model: pause takes effect 2 sync cycles late; a press lands 2+DEB+1
    // cycles after the button falls and beats any coincident step.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= 0;
            m_pos   <= 0;
            m_phase <= 0;
            h1      <= 1'b1;
            h2      <= 1'b1;
        end else begin
            m_cyc <= m_cyc + 1;
            h1    <= pause_n;
            h2    <= h1;
            if (m_cyc + 1 == m_press_edge) begin
                m_mode  <= (m_mode + 1) % 4;
                m_pos   <= 0;
                m_phase <= 0;
            end else if (h2) begin
                if (m_phase == TD - 1) begin
                    m_pos   <= m_pos + 1;
                    m_phase <= 0;
                end else begin
                    m_phase <= m_phase + 1;
                end
            end
        end
    end

    // Button driver: holds the button low for btn_len cycles per request
    initial begin
        btn_n = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (btn_left > 0) begin
                btn_left--;
                if (btn_left == 0) btn_n = 1'b1;
            end else if (btn_seq != btn_ack) begin
                btn_n    = 1'b0;
                btn_left = btn_len;
                btn_ack  = btn_seq;
                if (btn_len >= DEB) m_press_edge = m_cyc + DEB + 3;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic req_press(input int len);
        btn_len = len;
        btn_seq++;
        #2;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        pause_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (led !== 8'h01 || mode !== 2'd0) begin
            errors++;
            $display("FAIL reset_state LED=%h MODE=%0d expected LED=01 MODE=0", led, mode);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 9 * TD; k++) begin
            cycle();
            checks++;
            if (led !== exp_led() || mode !== 2'(m_mode)) begin
                errors++;
                $display("FAIL walk cyc=%0d LED=%h MODE=%0d expected LED=%h MODE=%0d",
                         m_cyc, led, mode, exp_led(), m_mode);
            end
        end
        checks++;
        if (led !== 8'h02) begin
            errors++;
            $display("FAIL walk_9_ticks LED=%h expected 02", led);
        end
    endtask

    task automatic test_bounce();
        req_press(DEB + $urandom_range(0, 4));
        for (int k = 0; k < 40 && m_cyc != m_press_edge; k++) cycle();
        checks++;
        if (m_cyc != m_press_edge || led !== 8'h01 || mode !== 2'd1) begin
            errors++;
            $display("FAIL bounce_entry LED=%h MODE=%0d expected LED=01 MODE=1", led, mode);
        end
        for (int k = 0; k < 15 * TD; k++) begin
            cycle();
            checks++;
            if (led !== exp_led() || mode !== 2'(m_mode)) begin
                errors++;
                $display("FAIL bounce cyc=%0d LED=%h MODE=%0d expected LED=%h MODE=%0d",
                         m_cyc, led, mode, exp_led(), m_mode);
            end
        end
        checks++;
        if (led !== 8'h02) begin
            errors++;
            $display("FAIL bounce_15_ticks LED=%h expected 02", led);
        end
    endtask

    task automatic advance_to_mode(input int target);
        for (int n = 0; n < 5 && m_mode != target; n++) begin
            req_press(DEB + $urandom_range(0, 2));
            for (int k = 0; k < 20; k++) begin
                cycle();
                checks++;
                if (led !== exp_led() || mode !== 2'(m_mode)) begin
                    errors++;
                    $display("FAIL mode_step cyc=%0d LED=%h MODE=%0d expected LED=%h MODE=%0d",
                             m_cyc, led, mode, exp_led(), m_mode);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int saved;
        saved = m_mode;
        req_press($urandom_range(1, DEB - 1));
        for (int k = 0; k < 20; k++) begin
            cycle();
            checks++;
            if (led !== exp_led() || mode !== 2'(m_mode)) begin
                errors++;
                $display("FAIL glitch cyc=%0d LED=%h MODE=%0d expected LED=%h MODE=%0d",
                         m_cyc, led, mode, exp_led(), m_mode);
            end
        end
        checks++;
        if (mode !== 2'(saved)) begin
            errors++;
            $display("FAIL glitch_no_press MODE=%0d expected %0d", mode, saved);
        end
        req_press(10);
        for (int k = 0; k < 30; k++) begin
            cycle();
            checks++;
            if (led !== exp_led() || mode !== 2'(m_mode)) begin
                errors++;
                $display("FAIL long_hold cyc=%0d LED=%h MODE=%0d expected LED=%h MODE=%0d",
                         m_cyc, led, mode, exp_led(), m_mode);
            end
        end
        checks++;
        if (mode !== 2'((saved + 1) % 4)) begin
            errors++;
            $display("FAIL long_hold_one_advance MODE=%0d expected %0d", mode, (saved + 1) % 4);
        end
        advance_to_mode(3);
        req_press(DEB + 1);
        for (int k = 0; k < 40 && m_cyc != m_press_edge; k++) cycle();
        checks++;
        if (led !== 8'h01 || mode !== 2'd0) begin
            errors++;
            $display("FAIL fill_to_walk LED=%h MODE=%0d expected LED=01 MODE=0", led, mode);
        end
        repeat (15) cycle();
    endtask

    task automatic test_pause();
        logic [7:0] held;
        int len;
        advance_to_mode(2);
        repeat ($urandom_range(1, TD)) cycle();
        pause_n = 1'b0;
        len = 20 + $urandom_range(0, 5);
        held = 8'hxx;
        for (int k = 0; k < len; k++) begin
            cycle();
            checks++;
            if (led !== exp_led() || mode !== 2'(m_mode)) begin
                errors++;
                $display("FAIL pause cyc=%0d LED=%h MODE=%0d expected LED=%h MODE=%0d",
                         m_cyc, led, mode, exp_led(), m_mode);
            end
            if (k == 2) held = led;
            if (k > 2) begin
                checks++;
                if (led !== held) begin
                    errors++;
                    $display("FAIL pause_frozen cyc=%0d LED=%h expected %h", m_cyc, led, held);
                end
            end
        end
        pause_n = 1'b1;
        for (int k = 0; k < 3 * TD; k++) begin
            cycle();
            checks++;
            if (led !== exp_led() || mode !== 2'(m_mode)) begin
                errors++;
                $display("FAIL resume cyc=%0d LED=%h MODE=%0d expected LED=%h MODE=%0d",
                         m_cyc, led, mode, exp_led(), m_mode);
            end
        end
    endtask

    task automatic test_press_on_tick();
        logic [7:0] seed;
        logic [7:0] step1;
        for (int k = 0; k < 2 * TD && ((m_phase + DEB + 2) % TD) != TD - 1; k++) cycle();
        req_press(DEB + 1);
        for (int k = 0; k < 40 && m_cyc != m_press_edge; k++) cycle();
        seed  = pat(m_mode, 0);
        step1 = pat(m_mode, 1);
        checks++;
        if (led !== seed || mode !== 2'(m_mode)) begin
            errors++;
            $display("FAIL tick_press_seed LED=%h MODE=%0d expected LED=%h MODE=%0d",
                     led, mode, seed, m_mode);
        end
        for (int k = 1; k <= TD; k++) begin
            cycle();
            checks++;
            if (led !== ((k == TD) ? step1 : seed)) begin
                errors++;
                $display("FAIL tick_press_step k=%0d LED=%h expected %h",
                         k, led, (k == TD) ? step1 : seed);
            end
        end
        repeat (15) cycle();
    endtask

    task automatic test_reset_mid();
        advance_to_mode(3);
        for (int k = 0; k < 20 * TD && m_pos != 4; k++) cycle();
        checks++;
        if (led !== 8'h0F || mode !== 2'd3) begin
            errors++;
            $display("FAIL fill_0f LED=%h MODE=%0d expected LED=0F MODE=3", led, mode);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 8'h01 || mode !== 2'd0) begin
            errors++;
            $display("FAIL async_reset LED=%h MODE=%0d expected LED=01 MODE=0", led, mode);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= TD; k++) begin
            cycle();
            checks++;
            if (led !== ((k == TD) ? 8'h02 : 8'h01) || mode !== 2'd0) begin
                errors++;
                $display("FAIL walk_restart k=%0d LED=%h MODE=%0d expected LED=%h MODE=0",
                         k, led, mode, (k == TD) ? 8'h02 : 8'h01);
            end
        end
    endtask

    task automatic test_random();
        int len;
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 2) == 0) pause_n = ~pause_n;
            len = $urandom_range(1, 6);
            req_press(len);
            for (int k = 0; k < 20 + $urandom_range(0, 8); k++) begin
                cycle();
                checks++;
                if (led !== exp_led() || mode !== 2'(m_mode)) begin
                    errors++;
                    $display("FAIL random it=%0d cyc=%0d LED=%h MODE=%0d expected LED=%h MODE=%0d",
                             it, m_cyc, led, mode, exp_led(), m_mode);
                end
            end
        end
        pause_n = 1'b1;
        repeat (4) cycle();
    endtask

    initial begin
        rst_n   = 1'b0;
        pause_n = 1'b1;
        test_reset();
        test_bounce();
        test_glitch();
        test_pause();
        test_press_on_tick();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
